// File: rtl/aes_sbox_array.sv
`default_nettype none
// ============================================================================
// Module : aes_sbox_array
// Brief  : LANES parallel masked AES S-boxes (forward / inverse) behind a
//          PIPE_STAGES-deep valid/ready pipeline with optional output mask
//          refresh. Only (data share, mask share) pairs are ever registered.
// Rev    : 1.0  initial release
// ============================================================================

module aes_sbox_array #(
    parameter int LANES       = 4,
    parameter int PIPE_STAGES = 2
) (
    input  logic               Clk,
    input  logic               Rstn,
    input  logic               InValid,
    output logic               InReady,
    input  logic               EncDec,
    input  logic [8*LANES-1:0] DataIn,
    input  logic [8*LANES-1:0] MaskIn,
    input  logic               RefreshEn,
    input  logic [8*LANES-1:0] RndIn,
    input  logic               Flush,
    output logic               OutValid,
    input  logic               OutReady,
    output logic [8*LANES-1:0] DataOut,
    output logic [8*LANES-1:0] MaskOut,
    output logic               Busy
);

    localparam int         W            = 8 * LANES;
    localparam logic [7:0] AFFINE_C     = 8'h63;
    localparam logic [7:0] INV_AFFINE_C = 8'h05;
    localparam logic [7:0] GF_POLY      = 8'h1B;

    // ------------------------------------------------------------------------
    // GF(2^8) arithmetic over x^8 + x^4 + x^3 + x + 1
    // ------------------------------------------------------------------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        logic [7:0] bb;
        p  = 8'h00;
        t  = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) begin
                p = p ^ t;
            end
            t  = {t[6:0], 1'b0} ^ (t[7] ? GF_POLY : 8'h00);
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires)
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2;
        logic [7:0] a3;
        logic [7:0] a12;
        logic [7:0] a15;
        logic [7:0] a240;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a12  = gf_mul(a3, a3);
        a12  = gf_mul(a12, a12);
        a15  = gf_mul(a12, a3);
        a240 = a15;
        for (int i = 0; i < 4; i++) begin
            a240 = gf_mul(a240, a240);
        end
        return gf_mul(gf_mul(a240, a12), a2);
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] a);
        logic [7:0] v;
        v = gf_inv(a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]}
                 ^ {v[3:0], v[7:4]} ^ AFFINE_C;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] u;
        u = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ INV_AFFINE_C;
        return gf_inv(u);
    endfunction

    // ------------------------------------------------------------------------
    // Entry: per-lane masked substitution and optional refresh.
    // The output keeps the input mask share, so the data share becomes
    // S(x) ^ m. The refresh byte is folded in here so every stored pair
    // already carries the fresh mask; the beat's control is thereby fixed
    // at acceptance and later input changes cannot reach it.
    // ------------------------------------------------------------------------
    logic [W-1:0] entry_data;
    logic [W-1:0] entry_mask;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] lane_x;
        logic [7:0] lane_y;
        logic [7:0] lane_fresh;
        assign lane_x     = DataIn[8*l +: 8] ^ MaskIn[8*l +: 8];
        assign lane_y     = EncDec ? inv_sbox(lane_x) : fwd_sbox(lane_x);
        assign lane_fresh = RefreshEn ? RndIn[8*l +: 8] : 8'h00;
        assign entry_data[8*l +: 8] = lane_y ^ MaskIn[8*l +: 8] ^ lane_fresh;
        assign entry_mask[8*l +: 8] = MaskIn[8*l +: 8] ^ lane_fresh;
    end

    // ------------------------------------------------------------------------
    // Pipeline: all stages advance together or hold together
    // ------------------------------------------------------------------------
    logic [PIPE_STAGES-1:0] valid_vec;
    logic [W-1:0]           data_vec [PIPE_STAGES];
    logic [W-1:0]           mask_vec [PIPE_STAGES];
    logic                   advance;

    assign advance  = !OutValid || OutReady;
    assign InReady  = advance && !Flush;
    assign OutValid = valid_vec[PIPE_STAGES-1];
    assign DataOut  = data_vec[PIPE_STAGES-1];
    assign MaskOut  = mask_vec[PIPE_STAGES-1];
    assign Busy     = |valid_vec;

    for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_stage
        logic         in_valid;
        logic [W-1:0] in_data;
        logic [W-1:0] in_mask;
        logic         valid;
        logic [W-1:0] data;
        logic [W-1:0] mask;

        if (s == 0) begin : g_head
            assign in_valid = InValid;
            assign in_data  = entry_data;
            assign in_mask  = entry_mask;
        end else begin : g_body
            assign in_valid = valid_vec[s-1];
            assign in_data  = data_vec[s-1];
            assign in_mask  = mask_vec[s-1];
        end

        assign valid_vec[s] = valid;
        assign data_vec[s]  = data;
        assign mask_vec[s]  = mask;

        // Stage register: flush drops valids only; data loads only with a valid beat
        always_ff @(posedge Clk or negedge Rstn) begin
            if (!Rstn) begin
                valid <= 1'b0;
                data  <= '0;
                mask  <= '0;
            end else if (Flush) begin
                valid <= 1'b0;
            end else if (advance) begin
                valid <= in_valid;
                if (in_valid) begin
                    data <= in_data;
                    mask <= in_mask;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_aes_sbox_array.sv
`default_nettype none
// ============================================================================
// Module : tb_aes_sbox_array
// Brief  : Directed self-checking bench for aes_sbox_array (LANES=4,
//          PIPE_STAGES=2) with hand-computed FIPS-197 S-box values.
// Rev    : 1.0  initial release
// ============================================================================

module tb_aes_sbox_array;

    localparam int LANES       = 4;
    localparam int PIPE_STAGES = 2;
    localparam int W           = 8 * LANES;

    logic         Clk = 1'b0;
    logic         Rstn = 1'b0;
    logic         InValid = 1'b0;
    logic         InReady;
    logic         EncDec = 1'b0;
    logic [W-1:0] DataIn = '0;
    logic [W-1:0] MaskIn = '0;
    logic         RefreshEn = 1'b0;
    logic [W-1:0] RndIn = '0;
    logic         Flush = 1'b0;
    logic         OutValid;
    logic         OutReady = 1'b1;
    logic [W-1:0] DataOut;
    logic [W-1:0] MaskOut;
    logic         Busy;

    int tests = 0;
    int fails = 0;

    aes_sbox_array #(
        .LANES       (LANES),
        .PIPE_STAGES (PIPE_STAGES)
    ) dut (
        .Clk       (Clk),
        .Rstn      (Rstn),
        .InValid   (InValid),
        .InReady   (InReady),
        .EncDec    (EncDec),
        .DataIn    (DataIn),
        .MaskIn    (MaskIn),
        .RefreshEn (RefreshEn),
        .RndIn     (RndIn),
        .Flush     (Flush),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .DataOut   (DataOut),
        .MaskOut   (MaskOut),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    // Watchdog: never let the run hang
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Send one beat of plain values x under mask m, wait for its result
    task automatic run_single(input logic enc, input logic [W-1:0] x, input logic [W-1:0] m,
                              input logic re, input logic [W-1:0] r,
                              output logic [W-1:0] dout, output logic [W-1:0] mout);
        int n;
        InValid   = 1'b1;
        EncDec    = enc;
        DataIn    = x ^ m;
        MaskIn    = m;
        RefreshEn = re;
        RndIn     = r;
        @(negedge Clk);
        check("single_in_ready", InReady, 1);
        @(posedge Clk); #1;
        InValid   = 1'b0;
        EncDec    = ~enc;
        RefreshEn = ~re;
        RndIn     = $urandom;
        DataIn    = $urandom;
        MaskIn    = $urandom;
        n = 0;
        @(negedge Clk);
        while (!OutValid && n < 20) begin
            @(negedge Clk);
            n++;
        end
        check("single_latency", n, 1);
        dout = DataOut;
        mout = MaskOut;
        @(posedge Clk); #1;
    endtask

    logic [W-1:0] s_x   [4];
    logic [W-1:0] s_m   [4];
    logic [W-1:0] s_exp [4];
    logic         s_enc [4];
    logic [W-1:0] d_off, m_off, d_on, m_on, held;
    int           idx, got, seen;
    logic         accepted;

    initial begin
        // ---------------- reset state ----------------
        #12;
        check("reset_out_valid", OutValid, 0);
        check("reset_busy", Busy, 0);
        check("reset_data_out", DataOut, 0);
        check("reset_mask_out", MaskOut, 0);
        @(negedge Clk);
        Rstn = 1'b1;
        @(posedge Clk); #1;
        check("reset_in_ready", InReady, 1);

        // ---------------- back-to-back mixed enc/dec stream ----------------
        s_x[0] = 32'hFF10_5300; s_m[0] = 32'h9C3E_115A; s_enc[0] = 1'b0; s_exp[0] = 32'h16CA_ED63;
        s_x[1] = 32'h16CA_ED63; s_m[1] = $urandom;      s_enc[1] = 1'b1; s_exp[1] = 32'hFF10_5300;
        s_x[2] = 32'h0101_0101; s_m[2] = $urandom;      s_enc[2] = 1'b0; s_exp[2] = 32'h7C7C_7C7C;
        s_x[3] = 32'h7C7C_7C7C; s_m[3] = $urandom;      s_enc[3] = 1'b1; s_exp[3] = 32'h0101_0101;
        OutReady = 1'b1;
        for (int c = 0; c < 7; c++) begin
            if (c < 4) begin
                InValid = 1'b1;
                EncDec  = s_enc[c];
                MaskIn  = s_m[c];
                DataIn  = s_x[c] ^ s_m[c];
            end else begin
                InValid = 1'b0;
            end
            @(negedge Clk);
            if (c < 4) check("stream_in_ready", InReady, 1);
            if (c == 1) check("stream_not_early", OutValid, 0);
            if (c >= 2 && c < 6) begin
                check("stream_out_valid", OutValid, 1);
                check("stream_xor", DataOut ^ MaskOut, s_exp[c-2]);
            end
            if (c == 6) check("stream_drained", OutValid, 0);
            @(posedge Clk); #1;
        end

        // ---------------- refresh ----------------
        run_single(1'b0, 32'h0000_0001, 32'h0000_003C, 1'b0, 32'h0000_00FF, d_off, m_off);
        run_single(1'b0, 32'h0000_0001, 32'h0000_003C, 1'b1, 32'h0000_00FF, d_on, m_on);
        check("refresh_off_xor", d_off ^ m_off, 32'h6363_637C);
        check("refresh_on_xor", d_on ^ m_on, 32'h6363_637C);
        check("refresh_data_delta", d_on ^ d_off, 32'h0000_00FF);
        check("refresh_mask_delta", m_on ^ m_off, 32'h0000_00FF);

        // ---------------- backpressure ----------------
        s_x[0] = 32'h0000_0000; s_enc[0] = 1'b0; s_exp[0] = 32'h6363_6363;
        s_x[1] = 32'h0000_0000; s_enc[1] = 1'b1; s_exp[1] = 32'h5252_5252;
        s_x[2] = 32'h5353_5353; s_enc[2] = 1'b0; s_exp[2] = 32'hEDED_EDED;
        idx  = 0;
        got  = 0;
        held = '0;
        for (int c = 0; c < 14; c++) begin
            OutReady = (c >= 5);
            if (idx < 3) begin
                InValid = 1'b1;
                EncDec  = s_enc[idx];
                MaskIn  = $urandom;
                DataIn  = s_x[idx] ^ MaskIn;
            end else begin
                InValid = 1'b0;
            end
            @(negedge Clk);
            if (c == 2) begin
                check("bp_in_ready_drop", InReady, 0);
                held = DataOut;
            end
            if (c >= 2 && c <= 4) begin
                check("bp_hold_valid", OutValid, 1);
                check("bp_hold_xor", DataOut ^ MaskOut, s_exp[0]);
                check("bp_hold_data", DataOut, held);
            end
            if (OutValid && OutReady) begin
                if (got < 3) check("bp_order_xor", DataOut ^ MaskOut, s_exp[got]);
                got++;
            end
            accepted = InValid && InReady;
            @(posedge Clk); #1;
            if (accepted) idx++;
        end
        check("bp_beats_out", got, 3);
        check("bp_beats_in", idx, 3);

        // ---------------- flush ----------------
        OutReady = 1'b1;
        for (int c = 0; c < 2; c++) begin
            InValid = 1'b1;
            EncDec  = 1'b0;
            MaskIn  = $urandom;
            DataIn  = 32'h1111_1111 ^ MaskIn;
            @(posedge Clk); #1;
        end
        Flush  = 1'b1;
        DataIn = 32'h2222_2222;
        @(negedge Clk);
        check("flush_in_ready", InReady, 0);
        check("flush_busy_before", Busy, 1);
        @(posedge Clk); #1;
        Flush   = 1'b0;
        InValid = 1'b0;
        @(negedge Clk);
        check("flush_out_valid", OutValid, 0);
        check("flush_busy_after", Busy, 0);
        @(posedge Clk); #1;
        run_single(1'b1, 32'hEDED_EDED, $urandom, 1'b0, '0, d_on, m_on);
        check("flush_next_xor", d_on ^ m_on, 32'h5353_5353);

        // ---------------- reset mid-stream ----------------
        for (int c = 0; c < 2; c++) begin
            InValid = 1'b1;
            EncDec  = 1'b0;
            MaskIn  = $urandom;
            DataIn  = 32'h0000_0000 ^ MaskIn;
            @(posedge Clk); #1;
        end
        InValid = 1'b0;
        Rstn    = 1'b0;
        #1;
        check("midrst_out_valid", OutValid, 0);
        check("midrst_busy", Busy, 0);
        check("midrst_data_out", DataOut, 0);
        check("midrst_mask_out", MaskOut, 0);
        @(negedge Clk);
        @(negedge Clk);
        Rstn = 1'b1;
        @(posedge Clk); #1;
        check("midrst_in_ready", InReady, 1);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge Clk);
            if (OutValid) seen++;
        end
        check("midrst_no_stale", seen, 0);
        @(posedge Clk); #1;
        run_single(1'b0, 32'h1000_FF53, $urandom, 1'b0, '0, d_on, m_on);
        check("midrst_next_xor", d_on ^ m_on, 32'hCA63_16ED);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/aes_sbox_array.md
AES_SBOX_ARRAY -- requirements
Module: aes_sbox_array

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel byte S-box lanes (1..16).
REQ-002 SHALL have parameter PIPE_STAGES, default 2, register stages from input to output (1..4).
REQ-003 SHALL have port Clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port Rstn, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port InValid, input, 1, input beat present.
REQ-006 SHALL have port InReady, output, 1, input beat accepted when InValid&&InReady.
REQ-007 SHALL have port EncDec, input, 1, 0=forward S-box, 1=inverse S-box; sampled per beat.
REQ-008 SHALL have port DataIn, input, 8*LANES, masked bytes (x^m), lane i at [8i+7:8i].
REQ-009 SHALL have port MaskIn, input, 8*LANES, input mask shares.
REQ-010 SHALL have port RefreshEn, input, 1, apply output mask refresh to this beat.
REQ-011 SHALL have port RndIn, input, 8*LANES, fresh randomness for refresh.
REQ-012 SHALL have port Flush, input, 1, synchronous discard of all in-flight beats.
REQ-013 SHALL have port OutValid, output, 1, output beat present.
REQ-014 SHALL have port OutReady, input, 1, output beat consumed when OutValid&&OutReady.
REQ-015 SHALL have port DataOut, output, 8*LANES, masked result share.
REQ-016 SHALL have port MaskOut, output, 8*LANES, result mask share.
REQ-017 SHALL have port Busy, output, 1, any stage holds a valid beat.

Function
REQ-018 SHALL, per lane, guarantee DataOut^MaskOut = S(DataIn^MaskIn) for EncDec=0, InvS(DataIn^MaskIn) for EncDec=1 (FIPS-197 tables).
REQ-019 SHALL never combine DataIn and MaskIn of a lane unmasked in any register; only share pairs are stored.
REQ-020 SHALL define Adv = !OutValid || OutReady; all stages shift together when Adv=1, all hold when Adv=0 (no bubble collapse).
REQ-021 SHALL drive InReady = Adv && !Flush, combinationally.
REQ-022 SHALL give latency exactly PIPE_STAGES cycles from acceptance to OutValid when OutReady stays 1.
REQ-023 SHALL sustain one beat per cycle throughput with OutReady=1.
REQ-024 SHALL carry EncDec, RefreshEn, RndIn with their beat through the pipeline; changes after acceptance do not affect that beat.
REQ-025 SHALL, when RefreshEn=1 for a beat, XOR RndIn lane i into both DataOut and MaskOut lane i; sum invariant of REQ-018 unchanged.
REQ-026 SHALL load stage data registers only when a valid beat enters that stage; bubbles leave data registers unchanged.
REQ-027 SHALL hold DataOut/MaskOut stable while OutValid=1 and OutReady=0, and hold last value after the beat leaves.
REQ-028 SHALL, on Flush=1, clear all stage valid bits and OutValid at next edge, data registers unchanged; Flush wins over simultaneous InValid.
REQ-029 SHALL drive Busy = OR of all stage valid bits including OutValid.
REQ-030 SHALL support mixed EncDec on consecutive beats without bubbles.

Reset
REQ-031 SHALL, on Rstn low, asynchronously clear all valid bits, OutValid=0, Busy=0, DataOut=0, MaskOut=0, all pipeline data registers 0.
REQ-032 SHALL drive InReady=1 from the first cycle after Rstn deasserts (Flush=0).
REQ-033 SHALL discard in-flight beats when reset asserts mid-operation; none reappear after release.

Verification
REQ-034 SHALL verify LANES=4, PIPE_STAGES=2, EncDec=0, lane0 DataIn=0x5A MaskIn=0x5A (x=0x00), lane1 x=0x53 -> OutValid at cycle 2, lane0 XOR=0x63, lane1 XOR=0xED.
REQ-035 SHALL verify EncDec=1, x=0x63 and x=0xED with random masks -> XOR 0x00 and 0x53; back-to-back alternate enc/dec beats stream without gaps.
REQ-036 SHALL verify RefreshEn=1, RndIn lane0=0xFF, x=0x01 -> DataOut/MaskOut each differ from RefreshEn=0 run by 0xFF, XOR still 0x7C.
REQ-037 SHALL verify OutReady=0 for 5 cycles with 3 beats offered -> InReady drops once OutValid=1, output holds, no beat lost/duplicated, order kept.
REQ-038 SHALL verify Flush asserted with InValid=1 and 2 beats in flight -> InReady=0 that cycle, OutValid=0 and Busy=0 next cycle, next accepted beat returns correctly.
REQ-039 SHALL verify Rstn pulsed low mid-stream -> all outputs 0 immediately, no stale OutValid after release.
